// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: drives a req/ack data-memory transaction from EX/MEM
// controls, stalls the pipeline while it is in flight, and holds the MEM/WB register.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_MEM_RegWrite,
    input  logic        EX_MEM_MemtoReg,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic [31:0] DataMemoryAddress,
    input  logic [31:0] DataMemoryWriteData,
    input  logic [4:0]  EX_MEM_RegisterRd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        MEM_Stall,
    output logic        MEM_Misaligned,
    output logic        MEM_BusError,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_MemtoReg,
    output logic [31:0] MEM_WB_ReadData,
    output logic [31:0] MEM_WB_ALUResult,
    output logic [4:0]  MEM_WB_RegisterRd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_misaligned;
    logic        r_buserr;
    logic        r_wb_regwrite;
    logic        r_wb_memtoreg;
    logic [31:0] r_wb_readdata;
    logic [31:0] r_wb_aluresult;
    logic [4:0]  r_wb_rd;

    logic        w_op;
    logic        w_aligned;
    logic        w_pass;

    assign w_op      = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign w_aligned = (DataMemoryAddress[1:0] == 2'b00);
    // MEM/WB takes real instruction data only for non-memory ops in IDLE or on op completion.
    assign w_pass    = ((r_state == S_IDLE) && !w_op) || (r_state == S_DONE);

    assign MEM_Stall = ((r_state == S_IDLE) && w_op && w_aligned) || (r_state == S_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_misaligned <= 1'b0;
            r_buserr     <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            r_buserr     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_op && !w_aligned) begin
                        r_misaligned <= 1'b1;
                    end else if (w_op) begin
                        r_state <= S_BUSY;
                        r_req   <= 1'b1;
                        r_we    <= EX_MEM_MemWrite;
                        r_addr  <= {DataMemoryAddress[31:2], 2'b00};
                        r_wdata <= DataMemoryWriteData;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (mem_ack) begin
                        r_rdata <= r_we ? '0 : mem_rdata;
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_cnt == LAST_CNT) begin
                        r_rdata  <= '0;
                        r_req    <= 1'b0;
                        r_buserr <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_readdata  <= '0;
            r_wb_aluresult <= '0;
            r_wb_rd        <= '0;
        end else if (w_pass) begin
            r_wb_regwrite  <= EX_MEM_RegWrite;
            r_wb_memtoreg  <= EX_MEM_MemtoReg;
            r_wb_readdata  <= (r_state == S_DONE) ? r_rdata : '0;
            r_wb_aluresult <= DataMemoryAddress;
            r_wb_rd        <= EX_MEM_RegisterRd;
        end else begin
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_readdata  <= '0;
            r_wb_aluresult <= '0;
            r_wb_rd        <= '0;
        end
    end

    assign mem_req           = r_req;
    assign mem_we            = r_we;
    assign mem_addr          = r_addr;
    assign mem_wdata         = r_wdata;
    assign MEM_Misaligned    = r_misaligned;
    assign MEM_BusError      = r_buserr;
    assign MEM_WB_RegWrite   = r_wb_regwrite;
    assign MEM_WB_MemtoReg   = r_wb_memtoreg;
    assign MEM_WB_ReadData   = r_wb_readdata;
    assign MEM_WB_ALUResult  = r_wb_aluresult;
    assign MEM_WB_RegisterRd = r_wb_rd;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed cases followed by random transactions
// checked against a transaction-level model of the stall/latency rules.
module tb_mem_stage_ctrl;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        EX_MEM_RegWrite = 1'b0;
    logic        EX_MEM_MemtoReg = 1'b0;
    logic        EX_MEM_MemRead = 1'b0;
    logic        EX_MEM_MemWrite = 1'b0;
    logic [31:0] DataMemoryAddress = '0;
    logic [31:0] DataMemoryWriteData = '0;
    logic [4:0]  EX_MEM_RegisterRd = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        MEM_Stall;
    logic        MEM_Misaligned;
    logic        MEM_BusError;
    logic        MEM_WB_RegWrite;
    logic        MEM_WB_MemtoReg;
    logic [31:0] MEM_WB_ReadData;
    logic [31:0] MEM_WB_ALUResult;
    logic [4:0]  MEM_WB_RegisterRd;

    int vectors = 0;
    int miscompares = 0;

    mem_stage_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemtoReg(EX_MEM_MemtoReg),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .DataMemoryAddress(DataMemoryAddress), .DataMemoryWriteData(DataMemoryWriteData),
        .EX_MEM_RegisterRd(EX_MEM_RegisterRd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .MEM_Stall(MEM_Stall), .MEM_Misaligned(MEM_Misaligned), .MEM_BusError(MEM_BusError),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_MemtoReg(MEM_WB_MemtoReg),
        .MEM_WB_ReadData(MEM_WB_ReadData), .MEM_WB_ALUResult(MEM_WB_ALUResult),
        .MEM_WB_RegisterRd(MEM_WB_RegisterRd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(mem_req), 0);
        chk({tag, "_we"},    32'(mem_we), 0);
        chk({tag, "_addr"},  mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_stall"}, 32'(MEM_Stall), 0);
        chk({tag, "_mis"},   32'(MEM_Misaligned), 0);
        chk({tag, "_berr"},  32'(MEM_BusError), 0);
        chk({tag, "_wb_rw"}, 32'(MEM_WB_RegWrite), 0);
        chk({tag, "_wb_m2r"}, 32'(MEM_WB_MemtoReg), 0);
        chk({tag, "_wb_rd_data"}, MEM_WB_ReadData, 0);
        chk({tag, "_wb_alu"}, MEM_WB_ALUResult, 0);
        chk({tag, "_wb_rd"}, 32'(MEM_WB_RegisterRd), 0);
    endtask

    // One pipeline instruction; ack arrives on BUSY cycle d (d > T never acks). Called at posedge+1.
    task automatic run_txn(input logic rw, input logic mr, input logic mw, input logic mtr,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input logic [4:0] rd, input int unsigned d);
        logic        op, mis, memop, tout;
        int unsigned exp_busy, exp_stall;
        logic [31:0] exp_rdata;
        int unsigned stalls, busy, berr;
        logic        done;
        op        = mr | mw;
        mis       = op && (addr[1:0] != 2'b00);
        memop     = op && !mis;
        tout      = memop && (d > T);
        exp_busy  = memop ? ((d > T) ? T : d) : 0;
        exp_stall = memop ? exp_busy + 1 : 0;
        exp_rdata = (mw || tout) ? 32'h0 : rdata;

        EX_MEM_RegWrite = rw; EX_MEM_MemtoReg = mtr;
        EX_MEM_MemRead = mr;  EX_MEM_MemWrite = mw;
        DataMemoryAddress = addr; DataMemoryWriteData = wd; EX_MEM_RegisterRd = rd;
        stalls = 0; busy = 0; berr = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_req) begin
                busy++;
                chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                chk("mem_we", 32'(mem_we), 32'(mw));
                if (mw) chk("mem_wdata", mem_wdata, wd);
                chk("busy_bubble", 32'(MEM_WB_RegWrite), 0);
                mem_ack   = (busy == d);
                mem_rdata = (busy == d) ? rdata : $urandom;
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            if (MEM_BusError) berr++;
            if (MEM_Stall) stalls++;
            else done = 1'b1;
        end
        chk("txn_completes", 32'(done), 1);
        chk("stall_cycles", stalls, exp_stall);
        chk("busy_cycles", busy, exp_busy);
        chk("buserr_pulses", berr, tout ? 1 : 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("misaligned", 32'(MEM_Misaligned), 32'(mis));
        chk("wb_regwrite", 32'(MEM_WB_RegWrite), mis ? 0 : 32'(rw));
        chk("wb_memtoreg", 32'(MEM_WB_MemtoReg), mis ? 0 : 32'(mtr));
        if (!mis) begin
            chk("wb_aluresult", MEM_WB_ALUResult, addr);
            chk("wb_rd", 32'(MEM_WB_RegisterRd), 32'(rd));
        end
        if (memop) chk("wb_readdata", MEM_WB_ReadData, exp_rdata);
    endtask

    initial begin
        logic [31:0] a;
        int unsigned kind;

        #3;
        chk_all_zero("reset");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1);
        run_txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 5'd3, 2);
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'hCAFE_0001, 32'h1234_5678, 5'd0, 1);
        run_txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0042, 32'h0, 32'h5555_5555, 5'd9, 1);
        run_txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'hAAAA_AAAA, 5'd7, 100);
        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0204, 32'h0BAD_F00D, 32'h7777_7777, 5'd4, 3);
        run_txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 5'd6, T);

        // Asynchronous reset while a load is outstanding.
        EX_MEM_RegWrite = 1'b1; EX_MEM_MemtoReg = 1'b1; EX_MEM_MemRead = 1'b1; EX_MEM_MemWrite = 1'b0;
        DataMemoryAddress = 32'h0000_0440; EX_MEM_RegisterRd = 5'd11;
        @(posedge clk); #1;
        chk("pre_reset_req", 32'(mem_req), 1);
        #2;
        rst = 1'b1;
        EX_MEM_RegWrite = 1'b0; EX_MEM_MemtoReg = 1'b0; EX_MEM_MemRead = 1'b0;
        DataMemoryAddress = '0; EX_MEM_RegisterRd = '0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_req", 32'(mem_req), 0);
        chk("post_rst_stall", 32'(MEM_Stall), 0);

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_txn(1'($urandom_range(0, 1)), (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                    1'($urandom_range(0, 1)), a, $urandom, $urandom, 5'($urandom_range(0, 31)),
                    $urandom_range(1, 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
